multdiv_sequencer: RTL and testbench
====================================

# multdiv_sequencer

Sequences the shared multi-cycle multiply/divide unit for the execute stage. Detects a mult or div decode in execute, latches operands and destination, pulses the unit's start, stalls the pipeline until the unit reports ready or a timeout expires, then issues a one-cycle register writeback. On an unit exception or a timeout, the writeback is redirected to the status register with an exception code. Sits between execute-stage decode (mult/div signals), the register-read operands, the multdiv unit, and the writeback mux.

## Interface
- STATUS_REG, 5'd30: register index written on exception or timeout
- MULT_EXC, 32'd4: code written for a mult exception or timeout
- DIV_EXC, 32'd5: code written for a div exception or timeout
- TIMEOUT, 64: maximum BUSY cycles before abort (≥2)

- clock  in  1  single clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- mult_signal  in  1  execute instruction is mult
- div_signal  in  1  execute instruction is div
- flush  in  1  squash execute stage (branch/jump taken)
- operand_a, operand_b  in  32  register-read operands
- dest_reg  in  5  destination register of execute instruction
- unit_result  in  32  multdiv result
- unit_ready  in  1  result valid (single-cycle pulse or level)
- unit_exception  in  1  qualifies unit_ready: overflow or divide-by-zero
- unit_ctrl_mult, unit_ctrl_div  out  1  one-cycle start pulses
- unit_a, unit_b  out  32  latched operands, stable from START until IDLE
- unit_abort  out  1  one-cycle pulse when an operation is abandoned
- stall  out  1  freeze fetch/decode/execute
- wb_valid  out  1  one-cycle writeback strobe
- wb_reg  out  5  writeback register
- wb_data  out  32  writeback data

## Operation
- States: IDLE, START, BUSY, DONE. Registered: state, op_is_div, unit_a/b, dest latch, result latch, exc flag, timeout counter (width clog2(TIMEOUT+1)).
- IDLE: if (mult_signal|div_signal) & ~flush → latch operands/dest, op_is_div = div_signal & ~mult_signal (mult wins if both), → START. Otherwise stay.
- START: assert unit_ctrl_mult or unit_ctrl_div for exactly this cycle; clear counter; → BUSY.
- BUSY: counter increments each cycle. unit_ready → latch unit_result and unit_exception, → DONE. Else counter == TIMEOUT-1 → set exc, → DONE, pulse unit_abort. flush (higher priority than ready/timeout) → pulse unit_abort, → IDLE, no writeback.
- START with flush: no start pulse issued; → IDLE, no abort pulse.
- DONE: wb_valid=1. No exception: wb_reg = dest latch, wb_data = result latch. Exception/timeout: wb_reg = STATUS_REG, wb_data = op_is_div ? DIV_EXC : MULT_EXC. Ignore mult/div/flush inputs; → IDLE.
- dest latch = 0 with no exception: wb_valid still pulses; the register file discards writes to r0.
- stall = (IDLE & (mult_signal|div_signal) & ~flush) | START | BUSY. Deasserted in DONE so that the held instruction retires exactly once.
- unit_ready seen in IDLE/START/DONE is ignored.

## Timing
- Reset (async): state=IDLE. All outputs 0, including unit_a/b, wb_reg, wb_data, and the counter.
- Detection in cycle N: stall is combinational in N. START occurs in N+1. BUSY starts in N+2.
- unit_ready first sampled in BUSY at N+2. If ready is high at N+2+k, DONE/wb_valid occurs at N+3+k and stall drops in that same cycle.
- Minimum op-to-writeback latency is 3 cycles, and the pipeline is stalled for 3 cycles.
- Timeout: DONE occurs at N+2+TIMEOUT if ready never arrives.
- Back-to-back ops: a new op can be detected in the cycle after DONE, which is IDLE.
- Reset asserted mid-operation returns the block to IDLE immediately. No writeback and no abort pulse are issued.

## Test plan
- mult, a=7, b=6, dest=5, ready at 4th BUSY cycle → ctrl_mult pulse at N+1. stall high N..N+5. wb_valid at N+6 with wb_reg=5, wb_data=42.
- div, a=9, b=0, unit_exception with ready → wb_reg=30, wb_data=5. No write to dest.
- mult with unit_ready never asserted, TIMEOUT=64 → unit_abort and wb_valid at N+66 with wb_reg=30, wb_data=4. stall drops the same cycle.
- div with flush asserted on the 2nd BUSY cycle → unit_abort pulse. IDLE next cycle. No wb_valid. stall low after the flush cycle.
- Two back-to-back mults (3×3→r1, 4×4→r2) → two wb_valid pulses carrying 9 then 16. ctrl_mult pulses exactly twice.
- reset asserted during BUSY → all outputs 0 asynchronously. A later unit_ready produces no writeback.

Source files
------------

// File: rtl/multdiv_sequencer_if.sv
// Handshake bundle between the execute stage, the shared multiply/divide
// unit, the writeback mux and the multdiv sequencer.
// The sequencer connects through the slave modport; the surrounding
// pipeline/unit model drives through the master modport.
interface multdiv_sequencer_if #(
    parameter int DATA_W = 32
);
    // Execute-stage decode and register-read operands
    logic              mult_signal;
    logic              div_signal;
    logic              flush;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [4:0]        dest_reg;

    // Multiply/divide unit response
    logic [DATA_W-1:0] unit_result;
    logic              unit_ready;
    logic              unit_exception;

    // Multiply/divide unit control
    logic              unit_ctrl_mult;
    logic              unit_ctrl_div;
    logic [DATA_W-1:0] unit_a;
    logic [DATA_W-1:0] unit_b;
    logic              unit_abort;

    // Pipeline control and writeback
    logic              stall;
    logic              wb_valid;
    logic [4:0]        wb_reg;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  mult_signal, div_signal, flush, operand_a, operand_b, dest_reg,
        input  unit_result, unit_ready, unit_exception,
        output unit_ctrl_mult, unit_ctrl_div, unit_a, unit_b, unit_abort,
        output stall, wb_valid, wb_reg, wb_data
    );

    modport master (
        output mult_signal, div_signal, flush, operand_a, operand_b, dest_reg,
        output unit_result, unit_ready, unit_exception,
        input  unit_ctrl_mult, unit_ctrl_div, unit_a, unit_b, unit_abort,
        input  stall, wb_valid, wb_reg, wb_data
    );
endinterface

// File: rtl/multdiv_sequencer.sv
// Multiply/divide sequencer for the execute stage.
// Catches a mult/div in execute, latches its operands and destination,
// kicks the shared multi-cycle unit, holds the pipeline until the unit
// answers (or a timeout fires), then issues a single writeback. Unit
// exceptions and timeouts are redirected to the status register as an
// exception code instead of the destination register.
module multdiv_sequencer #(
    parameter int                 DATA_W     = 32,
    parameter logic [4:0]         STATUS_REG = 5'd30,
    parameter logic [DATA_W-1:0]  MULT_EXC   = 32'd4,
    parameter logic [DATA_W-1:0]  DIV_EXC    = 32'd5,
    parameter int                 TIMEOUT    = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    multdiv_sequencer_if.slave    bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Counter must be able to hold TIMEOUT after its last increment.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q,     state_d;
    logic                op_is_div_q, op_is_div_d;
    logic [DATA_W-1:0]   a_q,         a_d;
    logic [DATA_W-1:0]   b_q,         b_d;
    logic [4:0]          dest_q,      dest_d;
    logic [DATA_W-1:0]   result_q,    result_d;
    logic                exc_q,       exc_d;
    logic                timed_out_q, timed_out_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;

    // A new operation is accepted only when execute holds a live mult/div.
    logic                req_go;
    assign req_go = (bus.mult_signal | bus.div_signal) & ~bus.flush;

    // State register and all latched data; async reset clears everything
    // so no stale operand or writeback value is visible after reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_is_div_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            dest_q      <= '0;
            result_q    <= '0;
            exc_q       <= 1'b0;
            timed_out_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            op_is_div_q <= op_is_div_d;
            a_q         <= a_d;
            b_q         <= b_d;
            dest_q      <= dest_d;
            result_q    <= result_d;
            exc_q       <= exc_d;
            timed_out_q <= timed_out_d;
            cnt_q       <= cnt_d;
        end
    end

    // Next-state logic: flush beats ready, ready beats timeout in BUSY.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_go) begin
                    state_d = START;
                end
            end
            START: begin
                state_d = bus.flush ? IDLE : BUSY;
            end
            BUSY: begin
                if (bus.flush) begin
                    state_d = IDLE;
                end else if (bus.unit_ready) begin
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand/result capture, exception flag and BUSY-cycle counter.
    always_comb begin
        op_is_div_d = op_is_div_q;
        a_d         = a_q;
        b_d         = b_q;
        dest_d      = dest_q;
        result_d    = result_q;
        exc_d       = exc_q;
        cnt_d       = cnt_q;
        // Only ever set for the single cycle entering DONE after a timeout.
        timed_out_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_go) begin
                    // mult wins when decode flags both
                    op_is_div_d = bus.div_signal & ~bus.mult_signal;
                    a_d         = bus.operand_a;
                    b_d         = bus.operand_b;
                    dest_d      = bus.dest_reg;
                    exc_d       = 1'b0;
                end
            end
            START: begin
                cnt_d = '0;
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!bus.flush) begin
                    if (bus.unit_ready) begin
                        result_d = bus.unit_result;
                        exc_d    = bus.unit_exception;
                    end else if (cnt_q == CNT_LAST) begin
                        exc_d       = 1'b1;
                        timed_out_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Outputs: start pulses in START, stall through BUSY, writeback in DONE.
    // A flush abort is raised in the BUSY cycle that sees the flush; a
    // timeout abort coincides with the redirected writeback in DONE.
    always_comb begin
        bus.unit_ctrl_mult = 1'b0;
        bus.unit_ctrl_div  = 1'b0;
        bus.unit_abort     = 1'b0;
        bus.stall          = 1'b0;
        bus.wb_valid       = 1'b0;
        bus.wb_reg         = '0;
        bus.wb_data        = '0;
        bus.unit_a         = a_q;
        bus.unit_b         = b_q;
        case (state_q)
            IDLE: begin
                bus.stall = req_go;
            end
            START: begin
                bus.stall          = 1'b1;
                bus.unit_ctrl_mult = ~bus.flush & ~op_is_div_q;
                bus.unit_ctrl_div  = ~bus.flush &  op_is_div_q;
            end
            BUSY: begin
                bus.stall      = 1'b1;
                bus.unit_abort = bus.flush;
            end
            DONE: begin
                bus.wb_valid   = 1'b1;
                bus.unit_abort = timed_out_q;
                if (exc_q) begin
                    bus.wb_reg  = STATUS_REG;
                    bus.wb_data = op_is_div_q ? DIV_EXC : MULT_EXC;
                end else begin
                    bus.wb_reg  = dest_q;
                    bus.wb_data = result_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: a table of complete operations with
// hand-computed writeback expectations, plus directed flush, back-to-back
// and reset-during-operation sequences.
module tb_multdiv_sequencer;

    logic clock;
    logic reset;

    multdiv_sequencer_if bus ();

    multdiv_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int cm_pulses = 0;

    always @(posedge clock) begin
        if (bus.unit_ctrl_mult) cm_pulses <= cm_pulses + 1;
    end

    typedef struct {
        logic        is_mult;
        logic        is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  dest;
        logic        rdy_en;     // unit ever answers
        int          ready_at;   // cycle offset from detection when ready rises
        logic [31:0] result;
        logic        exc;
        int          exp_done;   // cycle offset of DONE / wb_valid
        logic        exp_cm;
        logic        exp_cd;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        logic        exp_abort;
    } vec_t;

    vec_t vecs[7];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        bus.mult_signal    = 1'b0;
        bus.div_signal     = 1'b0;
        bus.flush          = 1'b0;
        bus.operand_a      = 32'h0;
        bus.operand_b      = 32'h0;
        bus.dest_reg       = 5'd0;
        bus.unit_result    = 32'h0;
        bus.unit_ready     = 1'b0;
        bus.unit_exception = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1 ({tag, " stall"},     bus.stall,          1'b0);
        chk1 ({tag, " ctrl_mult"}, bus.unit_ctrl_mult, 1'b0);
        chk1 ({tag, " ctrl_div"},  bus.unit_ctrl_div,  1'b0);
        chk1 ({tag, " abort"},     bus.unit_abort,     1'b0);
        chk1 ({tag, " wb_valid"},  bus.wb_valid,       1'b0);
        chk32({tag, " wb_reg"},    32'(bus.wb_reg),    32'h0);
        chk32({tag, " wb_data"},   bus.wb_data,        32'h0);
        chk32({tag, " unit_a"},    bus.unit_a,         32'h0);
        chk32({tag, " unit_b"},    bus.unit_b,         32'h0);
    endtask

    // Runs one operation from detection (t=0) through DONE, holding the
    // decode flags while stalled and scrambling operands after t=0 so the
    // latched copies are what get checked.
    task automatic run_op(input int id, input vec_t v);
        string  p;
        logic   rdy;
        for (int t = 0; t <= v.exp_done; t++) begin
            @(negedge clock);
            p = $sformatf("op%0d t%0d", id, t);
            rdy = v.rdy_en && (t >= v.ready_at);
            bus.mult_signal    = v.is_mult;
            bus.div_signal     = v.is_div;
            bus.flush          = 1'b0;
            bus.operand_a      = (t == 0) ? v.a : ~v.a;
            bus.operand_b      = (t == 0) ? v.b : ~v.b;
            bus.dest_reg       = (t == 0) ? v.dest : ~v.dest;
            bus.unit_ready     = rdy;
            bus.unit_result    = (rdy && t == v.ready_at) ? v.result : 32'h0BAD_BEEF;
            bus.unit_exception = (rdy && t == v.ready_at) ? v.exc : 1'b0;
            #1;
            chk1({p, " stall"},     bus.stall,          t < v.exp_done);
            chk1({p, " ctrl_mult"}, bus.unit_ctrl_mult, (t == 1) ? v.exp_cm : 1'b0);
            chk1({p, " ctrl_div"},  bus.unit_ctrl_div,  (t == 1) ? v.exp_cd : 1'b0);
            chk1({p, " abort"},     bus.unit_abort,     (t == v.exp_done) ? v.exp_abort : 1'b0);
            chk1({p, " wb_valid"},  bus.wb_valid,       t == v.exp_done);
            if (t >= 1) begin
                chk32({p, " unit_a"}, bus.unit_a, v.a);
                chk32({p, " unit_b"}, bus.unit_b, v.b);
            end
            if (t == v.exp_done) begin
                chk32({p, " wb_reg"},  32'(bus.wb_reg), 32'(v.exp_reg));
                chk32({p, " wb_data"}, bus.wb_data,     v.exp_data);
            end
        end
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clock);
        drive_idle();
        #1;
        chk1({tag, " stall"},     bus.stall,          1'b0);
        chk1({tag, " ctrl_mult"}, bus.unit_ctrl_mult, 1'b0);
        chk1({tag, " ctrl_div"},  bus.unit_ctrl_div,  1'b0);
        chk1({tag, " abort"},     bus.unit_abort,     1'b0);
        chk1({tag, " wb_valid"},  bus.wb_valid,       1'b0);
    endtask

    initial begin
        int   base;
        vec_t e1;
        vec_t e2;

        //          mult  div   a             b      dest  rdy  at  result        exc   done cm    cd    reg    data   abort
        vecs[0] = '{1'b1, 1'b0, 32'd7,        32'd6, 5'd5, 1'b1, 5, 32'd42,       1'b0, 6,  1'b1, 1'b0, 5'd5,  32'd42,  1'b0};
        vecs[1] = '{1'b0, 1'b1, 32'd9,        32'd0, 5'd7, 1'b1, 2, 32'hDEAD,     1'b1, 3,  1'b0, 1'b1, 5'd30, 32'd5,   1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'd3,        32'd8, 5'd3, 1'b0, 0, 32'd24,       1'b0, 66, 1'b1, 1'b0, 5'd30, 32'd4,   1'b1};
        vecs[3] = '{1'b0, 1'b1, 32'd100,      32'd7, 5'd12,1'b1, 3, 32'd14,       1'b0, 4,  1'b0, 1'b1, 5'd12, 32'd14,  1'b0};
        vecs[4] = '{1'b1, 1'b0, 32'd16,       32'd32,5'd0, 1'b1, 2, 32'd512,      1'b0, 3,  1'b1, 1'b0, 5'd0,  32'd512, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'd2, 5'd6, 1'b1, 4, 32'hFFFFFFFE, 1'b1, 5,  1'b1, 1'b0, 5'd30, 32'd4,   1'b0};
        vecs[6] = '{1'b1, 1'b1, 32'd5,        32'd5, 5'd10,1'b1, 2, 32'd25,       1'b1, 3,  1'b1, 1'b0, 5'd30, 32'd4,   1'b0};

        // Reset state, checked asynchronously before any clock edge.
        reset = 1'b1;
        drive_idle();
        #1;
        chk_all_zero("reset");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;

        // Stray ready while idle must not produce a writeback.
        @(negedge clock);
        bus.unit_ready  = 1'b1;
        bus.unit_result = 32'h1234;
        #1;
        chk1("idle_ready wb_valid", bus.wb_valid, 1'b0);
        idle_cycle("idle_ready next");

        for (int i = 0; i < 7; i++) begin
            run_op(i, vecs[i]);
            idle_cycle($sformatf("op%0d idle", i));
        end

        // Flush on the second BUSY cycle of a div.
        @(negedge clock);
        drive_idle();
        bus.div_signal = 1'b1; bus.operand_a = 32'd20; bus.operand_b = 32'd4; bus.dest_reg = 5'd8;
        #1;
        chk1("fb t0 stall", bus.stall, 1'b1);
        @(negedge clock); #1;
        chk1("fb t1 ctrl_div", bus.unit_ctrl_div, 1'b1);
        @(negedge clock); #1;
        chk1("fb t2 stall", bus.stall, 1'b1);
        chk1("fb t2 abort", bus.unit_abort, 1'b0);
        @(negedge clock);
        bus.flush = 1'b1;
        #1;
        chk1("fb t3 abort", bus.unit_abort, 1'b1);
        chk1("fb t3 wb_valid", bus.wb_valid, 1'b0);
        @(negedge clock);
        drive_idle();
        bus.unit_ready = 1'b1; bus.unit_result = 32'd5;
        #1;
        chk1("fb t4 stall", bus.stall, 1'b0);
        chk1("fb t4 abort", bus.unit_abort, 1'b0);
        chk1("fb t4 wb_valid", bus.wb_valid, 1'b0);
        @(negedge clock); #1;
        chk1("fb t5 wb_valid", bus.wb_valid, 1'b0);
        chk1("fb t5 ctrl_div", bus.unit_ctrl_div, 1'b0);
        idle_cycle("fb t6");

        // Flush arriving in START: no start pulse, no abort.
        @(negedge clock);
        drive_idle();
        bus.mult_signal = 1'b1; bus.operand_a = 32'd1; bus.operand_b = 32'd2; bus.dest_reg = 5'd3;
        #1;
        chk1("fs t0 stall", bus.stall, 1'b1);
        @(negedge clock);
        bus.flush = 1'b1;
        #1;
        chk1("fs t1 ctrl_mult", bus.unit_ctrl_mult, 1'b0);
        chk1("fs t1 abort", bus.unit_abort, 1'b0);
        idle_cycle("fs t2");
        idle_cycle("fs t3");

        // Flush in IDLE: the instruction is never accepted.
        @(negedge clock);
        drive_idle();
        bus.mult_signal = 1'b1; bus.flush = 1'b1;
        #1;
        chk1("fi t0 stall", bus.stall, 1'b0);
        idle_cycle("fi t1");

        // Back-to-back mults with no gap between DONE and the next detection.
        base = cm_pulses;
        e1 = '{1'b1, 1'b0, 32'd3, 32'd3, 5'd1, 1'b1, 2, 32'd9,  1'b0, 3, 1'b1, 1'b0, 5'd1, 32'd9,  1'b0};
        e2 = '{1'b1, 1'b0, 32'd4, 32'd4, 5'd2, 1'b1, 2, 32'd16, 1'b0, 3, 1'b1, 1'b0, 5'd2, 32'd16, 1'b0};
        run_op(7, e1);
        run_op(8, e2);
        idle_cycle("b2b idle");
        idle_cycle("b2b idle2");
        chk32("b2b ctrl_mult pulses", 32'(cm_pulses - base), 32'd2);

        // Reset asserted asynchronously during BUSY.
        @(negedge clock);
        drive_idle();
        bus.mult_signal = 1'b1; bus.operand_a = 32'd11; bus.operand_b = 32'd13; bus.dest_reg = 5'd9;
        @(negedge clock);
        @(negedge clock);
        @(negedge clock);
        #1;
        chk1("rst busy stall", bus.stall, 1'b1);
        chk32("rst busy unit_a", bus.unit_a, 32'd11);
        #1;
        reset = 1'b1;
        bus.mult_signal = 1'b0;
        #1;
        chk_all_zero("rst mid");
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            bus.unit_ready = 1'b1; bus.unit_result = 32'd143;
            #1;
            chk1($sformatf("rst after%0d wb_valid", k), bus.wb_valid, 1'b0);
            chk1($sformatf("rst after%0d stall", k), bus.stall, 1'b0);
            chk1($sformatf("rst after%0d abort", k), bus.unit_abort, 1'b0);
        end
        idle_cycle("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
